// File: rtl/input_replay_if.sv
// Host write bus for the input replay memory:
// entry writes and sequence length loads.
interface input_replay_if #(
    parameter int BTN_W = 6,
    parameter int RUN_W = 8,
    parameter int DEPTH = 512
) ();
    localparam int AW = $clog2(DEPTH);

    logic                   host_we;
    logic [AW-1:0]          host_addr;
    logic [RUN_W+BTN_W-1:0] host_data;
    logic                   len_we;
    logic [AW:0]            len_val;

    modport master (
        output host_we, host_addr, host_data,
        output len_we, len_val
    );

    modport slave (
        input host_we, host_addr, host_data,
        input len_we, len_val
    );
endinterface

// File: rtl/input_replay.sv
// Run-length-encoded frame input player/recorder
// driving the game core's btn vector.
module input_replay #(
    parameter int BTN_W = 6,
    parameter int DEPTH = 512,
    parameter int RUN_W = 8,
    parameter int CNT_W = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int EW = RUN_W + BTN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_en,
    input  logic [BTN_W-1:0] live_btn,
    input  logic             cmd_play,
    input  logic             cmd_rec,
    input  logic             cmd_stop,
    input  logic             loop_en,
    input_replay_if.slave    host,
    output logic [BTN_W-1:0] btn,
    output logic [1:0]       state,
    output logic [AW:0]      length,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_PLAY  = 2'd2,
        S_REC   = 2'd3
    } st_t;

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    st_t              st;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    rdata;
    logic [BTN_W-1:0] rd_btn;
    logic [RUN_W-1:0] rd_run;
    logic [AW-1:0]    rptr, rptr_d;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    cur_idx;
    logic [BTN_W-1:0] cur_btn;
    logic [RUN_W-1:0] run;
    logic             have;
    logic             at_end;
    logic             prime_ph;

    logic             start_play, start_rec;
    logic             play_step, play_end;
    logic             rec_frame, rec_keep;
    logic             rec_push, rec_flush;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [EW-1:0]    mem_wd;

    function automatic logic is_last(
        input logic [AW-1:0] p,
        input logic [AW:0]   len
    );
        return ({1'b0, p} + (AW+1)'(1)) == len;
    endfunction

    function automatic logic [AW-1:0] wrap(
        input logic [AW-1:0] p,
        input logic [AW:0]   len
    );
        return is_last(p, len) ? '0 : p + AW'(1);
    endfunction

    assign state  = st;
    assign rd_btn = rdata[BTN_W-1:0];
    assign rd_run = rdata[EW-1:BTN_W];

    always_comb begin
        start_play = (st == S_IDLE) && !cmd_stop
                   && cmd_play && (length != '0);
        start_rec  = (st == S_IDLE) && !cmd_stop
                   && !cmd_play && cmd_rec;
        play_end   = (st == S_PLAY) && !cmd_stop
                   && frame_en && at_end && !loop_en;
        play_step  = (st == S_PLAY) && !cmd_stop
                   && frame_en && !(at_end && !loop_en);
        rec_frame  = (st == S_REC) && !cmd_stop && frame_en;
        rec_keep   = have && (live_btn == cur_btn)
                   && (run != RUN_MAX);
        rec_push   = rec_frame && have && !rec_keep;
        rec_flush  = (st == S_REC) && cmd_stop && have;

        // rdata always mirrors mem[rptr], so the next entry is ready
        // the cycle after a promotion even with back-to-back frames.
        rptr_d = rptr;
        if (start_play)
            rptr_d = '0;
        else if (st == S_PRIME && !prime_ph)
            rptr_d = wrap(rptr, length);
        else if (play_step && run == '0)
            rptr_d = wrap(rptr, length);

        mem_we = !rst && (((st == S_IDLE) && host.host_we)
               || rec_push || rec_flush);
        mem_wa = (st == S_IDLE) ? host.host_addr : wptr;
        mem_wd = (st == S_IDLE) ? host.host_data
                                : {run, cur_btn};
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
        rdata <= mem[rptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_IDLE;
            btn       <= '0;
            length    <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            rptr      <= '0;
            wptr      <= '0;
            cur_idx   <= '0;
            cur_btn   <= '0;
            run       <= '0;
            have      <= 1'b0;
            at_end    <= 1'b0;
            prime_ph  <= 1'b0;
        end else begin
            done <= 1'b0;
            rptr <= rptr_d;
            unique case (st)
                S_IDLE: begin
                    btn <= live_btn;
                    if (host.len_we)
                        length <= host.len_val;
                    if (start_play) begin
                        st        <= S_PRIME;
                        prime_ph  <= 1'b0;
                        frame_cnt <= '0;
                        btn       <= '0;
                    end else if (start_rec) begin
                        st        <= S_REC;
                        frame_cnt <= '0;
                        overflow  <= 1'b0;
                        wptr      <= '0;
                        have      <= 1'b0;
                        run       <= '0;
                    end
                end
                S_PRIME: begin
                    if (cmd_stop) begin
                        st <= S_IDLE;
                    end else if (!prime_ph) begin
                        prime_ph <= 1'b1;
                        cur_btn  <= rd_btn;
                        run      <= rd_run;
                        cur_idx  <= '0;
                        at_end   <= 1'b0;
                    end else begin
                        st <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (cmd_stop) begin
                        st <= S_IDLE;
                    end else if (play_end) begin
                        st   <= S_IDLE;
                        done <= 1'b1;
                        btn  <= live_btn;
                    end else if (play_step) begin
                        btn       <= cur_btn;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        at_end    <= 1'b0;
                        if (run == '0) begin
                            cur_btn <= rd_btn;
                            run     <= rd_run;
                            cur_idx <= wrap(cur_idx, length);
                            at_end  <= is_last(cur_idx, length);
                        end else begin
                            run <= run - RUN_W'(1);
                        end
                    end
                end
                S_REC: begin
                    btn <= live_btn;
                    if (cmd_stop) begin
                        st     <= S_IDLE;
                        length <= {1'b0, wptr}
                                + {{AW{1'b0}}, have};
                    end else if (rec_frame) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        if (!have) begin
                            have    <= 1'b1;
                            cur_btn <= live_btn;
                            run     <= '0;
                        end else if (rec_keep) begin
                            run <= run + RUN_W'(1);
                        end else if (wptr == AW'(DEPTH-1)) begin
                            // memory full: the frame that closed
                            // the last entry is dropped
                            st       <= S_IDLE;
                            length   <= (AW+1)'(DEPTH);
                            overflow <= 1'b1;
                        end else begin
                            wptr    <= wptr + AW'(1);
                            cur_btn <= live_btn;
                            run     <= '0;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_replay.sv
// Randomised self-checking bench for input_replay
// against a frame-list / run-length reference model.
module tb_input_replay;
    localparam int BTN_W = 6;
    localparam int DEPTH = 512;
    localparam int RUN_W = 8;
    localparam int CNT_W = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = RUN_W + BTN_W;
    localparam int MAXF  = 1 << RUN_W;
    localparam int D4    = 4;
    localparam int AW4   = $clog2(D4);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_en = 1'b0;
    logic             cmd_play = 1'b0;
    logic             cmd_rec = 1'b0;
    logic             cmd_stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [BTN_W-1:0] live_btn = '0;

    logic [BTN_W-1:0] btn, btn4;
    logic [1:0]       state, state4;
    logic [AW:0]      length;
    logic [AW4:0]     length4;
    logic [CNT_W-1:0] frame_cnt, frame_cnt4;
    logic             done, done4, overflow, overflow4;

    input_replay_if #(.BTN_W(BTN_W), .RUN_W(RUN_W),
                      .DEPTH(DEPTH)) hif ();
    input_replay_if #(.BTN_W(BTN_W), .RUN_W(RUN_W),
                      .DEPTH(D4)) hif4 ();

    input_replay #(.BTN_W(BTN_W), .DEPTH(DEPTH),
                   .RUN_W(RUN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .frame_en(frame_en),
        .live_btn(live_btn), .cmd_play(cmd_play),
        .cmd_rec(cmd_rec), .cmd_stop(cmd_stop),
        .loop_en(loop_en), .host(hif), .btn(btn),
        .state(state), .length(length),
        .frame_cnt(frame_cnt), .done(done),
        .overflow(overflow)
    );

    input_replay #(.BTN_W(BTN_W), .DEPTH(D4),
                   .RUN_W(RUN_W), .CNT_W(CNT_W)) dut4 (
        .clk(clk), .rst(rst), .frame_en(frame_en),
        .live_btn(live_btn), .cmd_play(cmd_play),
        .cmd_rec(cmd_rec), .cmd_stop(cmd_stop),
        .loop_en(loop_en), .host(hif4), .btn(btn4),
        .state(state4), .length(length4),
        .frame_cnt(frame_cnt4), .done(done4),
        .overflow(overflow4)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    bit [EW-1:0]    mdl_mem [DEPTH];
    int             mdl_len = 0;
    bit [BTN_W-1:0] exp_q [$];
    bit [BTN_W-1:0] rec_in [$];
    bit [EW-1:0]    enc [$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input bit [EW-1:0] d);
        hif.host_we   = 1'b1;
        hif.host_addr = AW'(a);
        hif.host_data = d;
        cyc();
        hif.host_we = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic set_len(input int n);
        hif.len_we  = 1'b1;
        hif.len_val = (AW+1)'(n);
        cyc();
        hif.len_we = 1'b0;
        mdl_len = n;
    endtask

    // Frame list: entry i contributes run+1 copies of its btn.
    task automatic expand();
        exp_q.delete();
        for (int i = 0; i < mdl_len; i++) begin
            int r;
            r = int'(mdl_mem[i][EW-1:BTN_W]);
            for (int k = 0; k <= r; k++)
                exp_q.push_back(mdl_mem[i][BTN_W-1:0]);
        end
    endtask

    // Groups of equal values, split into chunks of at most MAXF.
    task automatic encode(input int n);
        int i;
        int j;
        bit [BTN_W-1:0] v;
        enc.delete();
        i = 0;
        while (i < n) begin
            v = rec_in[i];
            j = i;
            while (j < n && rec_in[j] == v && j - i < MAXF)
                j++;
            enc.push_back({RUN_W'(j - i - 1), v});
            i = j;
        end
    endtask

    task automatic play(input string nm, input int nfr,
                        input bit lp, input bit gaps);
        bit [BTN_W-1:0] last;
        int total;
        expand();
        total = exp_q.size();
        loop_en = lp;
        cmd_play = 1'b1;
        cyc();
        cmd_play = 1'b0;
        ncmp++;
        if (state !== 2'd1 || btn !== '0) begin
            nerr++;
            $display("FAIL %s prime1: state=%0d btn=%h need 1/00",
                     nm, state, btn);
        end
        cyc();
        ncmp++;
        if (state !== 2'd1) begin
            nerr++;
            $display("FAIL %s prime2: state=%0d need 1", nm, state);
        end
        cyc();
        ncmp++;
        if (state !== 2'd2) begin
            nerr++;
            $display("FAIL %s play: state=%0d need 2", nm, state);
        end
        last = '0;
        for (int k = 0; k < nfr; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    cyc();
                    ncmp++;
                    if (btn !== last || state !== 2'd2) begin
                        nerr++;
                        $display("FAIL %s hold %0d: btn=%h need %h",
                                 nm, k, btn, last);
                    end
                end
            end
            frame_en = 1'b1;
            cyc();
            frame_en = 1'b0;
            last = exp_q[k % total];
            ncmp++;
            if (btn !== last || done !== 1'b0
                || state !== 2'd2) begin
                nerr++;
                $display("FAIL %s frame %0d: btn=%h need %h done=%b st=%0d",
                         nm, k, btn, last, done, state);
            end
        end
        ncmp++;
        if (frame_cnt !== CNT_W'(nfr)) begin
            nerr++;
            $display("FAIL %s frame_cnt: %0d need %0d",
                     nm, frame_cnt, nfr);
        end
        if (!lp) begin
            frame_en = 1'b1;
            cyc();
            frame_en = 1'b0;
            ncmp++;
            if (done !== 1'b1 || state !== 2'd0
                || frame_cnt !== CNT_W'(total)
                || btn !== live_btn) begin
                nerr++;
                $display("FAIL %s end: done=%b st=%0d cnt=%0d btn=%h need 1/0/%0d/%h",
                         nm, done, state, frame_cnt, btn,
                         total, live_btn);
            end
            cyc();
            ncmp++;
            if (done !== 1'b0) begin
                nerr++;
                $display("FAIL %s done_pulse: done=%b need 0",
                         nm, done);
            end
        end else begin
            cmd_stop = 1'b1;
            cyc();
            cmd_stop = 1'b0;
            ncmp++;
            if (state !== 2'd0 || done !== 1'b0) begin
                nerr++;
                $display("FAIL %s stop: st=%0d done=%b need 0/0",
                         nm, state, done);
            end
        end
        loop_en = 1'b0;
    endtask

    task automatic rec(input string nm);
        cmd_rec = 1'b1;
        cyc();
        cmd_rec = 1'b0;
        ncmp++;
        if (state !== 2'd3 || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL %s rec_start: st=%0d ovf=%b need 3/0",
                     nm, state, overflow);
        end
        foreach (rec_in[k]) begin
            live_btn = rec_in[k];
            frame_en = 1'b1;
            cyc();
            frame_en = 1'b0;
            ncmp++;
            if (btn !== rec_in[k] || state !== 2'd3) begin
                nerr++;
                $display("FAIL %s rec %0d: btn=%h need %h st=%0d",
                         nm, k, btn, rec_in[k], state);
            end
        end
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        encode(rec_in.size());
        ncmp++;
        if (state !== 2'd0 || length !== (AW+1)'(enc.size())
            || frame_cnt !== CNT_W'(rec_in.size())) begin
            nerr++;
            $display("FAIL %s rec_stop: st=%0d len=%0d cnt=%0d need 0/%0d/%0d",
                     nm, state, length, frame_cnt,
                     enc.size(), rec_in.size());
        end
        foreach (enc[i]) begin
            ncmp++;
            if (dut.mem[i] !== enc[i]) begin
                nerr++;
                $display("FAIL %s entry %0d: %h need %h",
                         nm, i, dut.mem[i], enc[i]);
            end
            mdl_mem[i] = enc[i];
        end
        mdl_len = enc.size();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        live_btn = 6'h15;
        repeat (3) cyc();
        ncmp++;
        if (state !== 2'd0) begin
            nerr++;
            $display("FAIL rst_state: %0d need 0", state);
        end
        ncmp++;
        if (btn !== '0) begin
            nerr++;
            $display("FAIL rst_btn: %h need 0", btn);
        end
        ncmp++;
        if (length !== '0 || frame_cnt !== '0) begin
            nerr++;
            $display("FAIL rst_len_cnt: %0d/%0d need 0/0",
                     length, frame_cnt);
        end
        ncmp++;
        if (done !== 1'b0 || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL rst_flags: done=%b ovf=%b need 0/0",
                     done, overflow);
        end
        rst = 1'b0;
        cyc();
        ncmp++;
        if (btn !== 6'h15 || state !== 2'd0) begin
            nerr++;
            $display("FAIL idle_pass: btn=%h need 15", btn);
        end
        live_btn = '0;
    endtask

    task automatic test_play();
        host_write(0, {8'd2, 6'h01});
        host_write(1, {8'd0, 6'h20});
        set_len(2);
        play("play", 4, 1'b0, 1'b0);
    endtask

    task automatic test_loop();
        play("loop", 10, 1'b1, 1'b0);
    endtask

    task automatic test_rec();
        rec_in = '{6'h03, 6'h03, 6'h03, 6'h10, 6'h10};
        rec("rec5");
        play("rec5_play", rec_in.size(), 1'b0, 1'b0);
    endtask

    task automatic test_rec_long();
        rec_in.delete();
        repeat (300) rec_in.push_back(6'h04);
        rec("rec300");
        play("rec300_play", rec_in.size(), 1'b0, 1'b0);
    endtask

    task automatic test_rec_empty();
        cmd_rec = 1'b1;
        cyc();
        cmd_rec = 1'b0;
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        ncmp++;
        if (state !== 2'd0 || length !== '0) begin
            nerr++;
            $display("FAIL rec_empty: st=%0d len=%0d need 0/0",
                     state, length);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n;
            int tot;
            bit lp;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                host_write(i, {RUN_W'($urandom_range(0, 3)),
                               BTN_W'($urandom)});
            set_len(n);
            expand();
            tot = exp_q.size();
            lp = 1'($urandom_range(0, 1));
            play("rand", lp ? tot + $urandom_range(1, tot) : tot,
                 lp, 1'b1);
        end
    endtask

    task automatic test_rec_random();
        for (int it = 0; it < 3; it++) begin
            bit [BTN_W-1:0] v;
            rec_in.delete();
            v = BTN_W'($urandom);
            repeat ($urandom_range(20, 60)) begin
                if ($urandom_range(0, 2) == 0)
                    v = BTN_W'($urandom_range(0, 3));
                rec_in.push_back(v);
            end
            rec("rrec");
            play("rrec_play", rec_in.size(), 1'b0, 1'b1);
        end
    endtask

    task automatic test_overflow();
        bit ovf_exp;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cmd_rec = 1'b1;
        cyc();
        cmd_rec = 1'b0;
        rec_in.delete();
        ovf_exp = 1'b0;
        for (int k = 0; k < 8 && !ovf_exp; k++) begin
            rec_in.push_back((k % 2 == 0) ? 6'h01 : 6'h02);
            live_btn = rec_in[k];
            frame_en = 1'b1;
            cyc();
            frame_en = 1'b0;
            encode(k + 1);
            ovf_exp = enc.size() > D4;
            ncmp++;
            if (overflow4 !== ovf_exp
                || state4 !== (ovf_exp ? 2'd0 : 2'd3)) begin
                nerr++;
                $display("FAIL ovf frame %0d: ovf=%b st=%0d need %b",
                         k, overflow4, state4, ovf_exp);
            end
        end
        ncmp++;
        if (length4 !== (AW4+1)'(D4) || !ovf_exp) begin
            nerr++;
            $display("FAIL ovf_len: len=%0d need %0d", length4, D4);
        end
        for (int i = 0; i < D4; i++) begin
            ncmp++;
            if (dut4.mem[i] !== enc[i]) begin
                nerr++;
                $display("FAIL ovf_entry %0d: %h need %h",
                         i, dut4.mem[i], enc[i]);
            end
        end
        ncmp++;
        if (overflow !== 1'b0 || state !== 2'd3) begin
            nerr++;
            $display("FAIL big_no_ovf: ovf=%b st=%0d need 0/3",
                     overflow, state);
        end
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        cmd_rec = 1'b1;
        cyc();
        cmd_rec = 1'b0;
        ncmp++;
        if (overflow4 !== 1'b0 || state4 !== 2'd3) begin
            nerr++;
            $display("FAIL ovf_clear: ovf=%b st=%0d need 0/3",
                     overflow4, state4);
        end
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
    endtask

    task automatic test_rst_mid();
        set_len(3);
        loop_en = 1'b1;
        cmd_play = 1'b1;
        cyc();
        cmd_play = 1'b0;
        repeat (2) cyc();
        frame_en = 1'b1;
        repeat (4) cyc();
        frame_en = 1'b0;
        ncmp++;
        if (state !== 2'd2) begin
            nerr++;
            $display("FAIL mid_play: st=%0d need 2", state);
        end
        rst = 1'b1;
        live_btn = 6'h2a;
        cyc();
        ncmp++;
        if (state !== 2'd0 || btn !== '0 || length !== '0
            || frame_cnt !== '0 || done !== 1'b0
            || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL mid_rst: st=%0d btn=%h len=%0d cnt=%0d need zeros",
                     state, btn, length, frame_cnt);
        end
        rst = 1'b0;
        loop_en = 1'b0;
        cmd_play = 1'b1;
        cyc();
        cmd_play = 1'b0;
        ncmp++;
        if (state !== 2'd0 || btn !== 6'h2a) begin
            nerr++;
            $display("FAIL play_len0: st=%0d btn=%h need 0/2a",
                     state, btn);
        end
        cyc();
        ncmp++;
        if (state !== 2'd0) begin
            nerr++;
            $display("FAIL play_len0_hold: st=%0d need 0", state);
        end
    endtask

    initial begin
        hif.host_we    = 1'b0;
        hif.host_addr  = '0;
        hif.host_data  = '0;
        hif.len_we     = 1'b0;
        hif.len_val    = '0;
        hif4.host_we   = 1'b0;
        hif4.host_addr = '0;
        hif4.host_data = '0;
        hif4.len_we    = 1'b0;
        hif4.len_val   = '0;
        test_reset();
        test_play();
        test_loop();
        test_rec();
        test_rec_long();
        test_rec_empty();
        test_random();
        test_rec_random();
        test_overflow();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
